bus_dma: RTL and testbench

- Second initiator on the CPU/BRam word bus. Copies a block of words from one address range to another, or fills a range with a constant pattern, without CPU involvement.
- Requests the bus with bus_req. Drives the bus only while the arbiter returns bus_gnt.
- Targets the single-port BRam responder. The responder is clocked on ~clock, so read data addressed in cycle N is valid at the next rising edge and writes land within cycle N.

---
 rtl/bus_dma.sv | 174 +++++++++++++++++
 tb/tb_bus_dma.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma.sv
// bus_dma: second bus initiator that copies a block of words (copy mode) or
//   fills a range with a constant (fill mode) on the shared CPU/BRam word bus.
// Latency: copy takes 2 cycles/word, fill 1 cycle/word; done pulses the cycle after the last write.
// Backpressure: bus_gnt=0 stalls the pending read or write with all bus outputs held.
// Ports: clock/reset (async, active-low); start/mode/src/dst/len/pattern command inputs;
//   busy/done status; bus_req/bus_gnt arbitration; bus_addr/bus_data_r/bus_data_w/
//   bus_mask_w/bus_write drive the single-port BRam responder (clocked on ~clock).
module bus_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      pattern,
  output logic             busy,
  output logic             done,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      bus_addr,
  input  logic [31:0]      bus_data_r,
  output logic [31:0]      bus_data_w,
  output logic [3:0]       bus_mask_w,
  output logic             bus_write
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_cur_q, src_cur_d;
  logic [31:0]      dst_cur_q, dst_cur_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;
  logic             write_q, write_d;

  always_comb begin
    state_d   = state_q;
    src_cur_d = src_cur_q;
    dst_cur_d = dst_cur_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    done_d    = done_q;
    req_d     = req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    write_d   = write_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            // Empty command: no bus traffic; the done pulse is raised from S_DONE.
            state_d = S_DONE;
          end else begin
            src_cur_d = src;
            dst_cur_d = dst;
            cnt_d     = len;
            mode_d    = mode;
            busy_d    = 1'b1;
            req_d     = 1'b1;
            if (mode) begin
              state_d = S_WRITE;
              addr_d  = dst;
              wdata_d = pattern;
              write_d = 1'b1;
              mask_d  = 4'b1111;
            end else begin
              state_d = S_READ;
              addr_d  = src;
            end
          end
        end
      end

      S_READ: begin
        // Responder returns data for the address presented this cycle by the next rising edge.
        if (bus_gnt) begin
          state_d = S_WRITE;
          wdata_d = bus_data_r;
          addr_d  = dst_cur_q;
          write_d = 1'b1;
          mask_d  = 4'b1111;
        end
      end

      S_WRITE: begin
        if (bus_gnt) begin
          cnt_d     = cnt_q - LEN_W'(1);
          src_cur_d = src_cur_q + 32'd1;
          dst_cur_d = dst_cur_q + 32'd1;
          write_d   = 1'b0;
          mask_d    = 4'b0000;
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end else if (mode_q) begin
            // Fill streams back-to-back writes; data register already holds the pattern.
            addr_d  = dst_cur_q + 32'd1;
            write_d = 1'b1;
            mask_d  = 4'b1111;
          end else begin
            state_d = S_READ;
            addr_d  = src_cur_q + 32'd1;
          end
        end
      end

      S_DONE: begin
        // Normal completion enters with done already set. The zero-length path
        // enters with done clear, so it spends one extra cycle here raising it.
        if (done_q) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      src_cur_q <= '0;
      dst_cur_q <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      write_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_cur_q <= src_cur_d;
      dst_cur_q <= dst_cur_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      write_q   <= write_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bus_req    = req_q;
  assign bus_addr   = addr_q;
  assign bus_data_w = wdata_q;
  assign bus_mask_w = mask_q;
  assign bus_write  = write_q;

endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: scoreboard bench for bus_dma with a BRam model clocked on the falling edge.
// Latency: expected writes are queued at command issue and popped as granted writes appear.
// Backpressure: grant is dropped for a programmable window to exercise read/write retries.
module tb_bus_dma;

  logic        clock = 1'b0;
  logic        reset, start, mode, bus_gnt;
  logic [31:0] src, dst, pattern, bus_data_r;
  logic [15:0] len;
  logic        busy, done, bus_req, bus_write;
  logic [31:0] bus_addr, bus_data_w;
  logic [3:0]  bus_mask_w;

  always #5 clock = ~clock;

  bus_dma #(.LEN_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .pattern(pattern),
    .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_addr(bus_addr), .bus_data_r(bus_data_r), .bus_data_w(bus_data_w),
    .bus_mask_w(bus_mask_w), .bus_write(bus_write)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] mem [bit [31:0]];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          wr_cyc = 0;
  bit          zero_mon = 1'b0;
  bit          zero_viol = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Untouched locations read back an address-derived value so stray writes are visible.
  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A0000;
  endfunction

  // BRam responder on ~clock plus write scoreboard.
  always @(negedge clock) begin
    wr_t e;
    if (done) done_cnt++;
    if (bus_write) wr_cyc++;
    if (zero_mon) zero_viol = zero_viol | busy | bus_req | bus_write;
    if (bus_write && bus_gnt) begin
      if (sb.size() == 0) begin
        chk("unexp_write", {31'b0, bus_write}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", bus_addr, e.a);
        chk("wr_data", bus_data_w, e.d);
        chk("wr_mask", {28'b0, bus_mask_w}, 32'hF);
      end
      mem[bus_addr] = bus_data_w;
    end
    bus_data_r = rd(bus_addr);
  end

  task automatic run_cmd(input string nm, input logic m, input logic [31:0] s,
                         input logic [31:0] d, input logic [15:0] n, input logic [31:0] pat,
                         input int stall_from, input int stall_len,
                         input int abort_edge, input int restart_edge);
    int          k, got, exp_edge, d0, w0;
    logic [31:0] exp0;
    wr_t         e;
    exp0 = m ? pat : rd(s);
    for (int i = 0; i < int'(n); i++) begin
      e.a = d + 32'(i);
      e.d = m ? pat : rd(s + 32'(i));
      sb.push_back(e);
    end
    exp_edge = (n == 16'd0) ? 1 : ((m ? int'(n) : 2 * int'(n)) + stall_len);
    d0 = done_cnt;
    w0 = wr_cyc;

    @(posedge clock); #1;
    start = 1'b1; mode = m; src = s; dst = d; len = n; pattern = pat; bus_gnt = 1'b1;
    @(posedge clock); #1;   // edge 0 samples the command
    start = 1'b0;
    k = 0;
    got = -1;
    while (k < 400) begin
      bus_gnt = !(k >= stall_from && k < stall_from + stall_len);
      if (k == restart_edge) begin
        start = 1'b1; mode = ~m; src = s + 32'h80; dst = d + 32'h80;
        len = 16'd5; pattern = 32'h0BAD0BAD;
      end else begin
        start = 1'b0;
      end
      if (k == abort_edge) begin
        chk({nm, "_pre_rst_write"}, {31'b0, bus_write}, 32'd1);
        reset = 1'b0;
        #1;
        chk({nm, "_rst_write"}, {31'b0, bus_write}, 32'd0);
        chk({nm, "_rst_busy"}, {31'b0, busy}, 32'd0);
        chk({nm, "_rst_req"}, {31'b0, bus_req}, 32'd0);
        break;
      end
      @(negedge clock);
      if (!bus_gnt) begin
        chk({nm, "_stall_addr"}, bus_addr, d);
        chk({nm, "_stall_data"}, bus_data_w, exp0);
        chk({nm, "_stall_write"}, {31'b0, bus_write}, 32'd1);
      end
      if (done) begin
        got = k;
        break;
      end
      @(posedge clock); #1;
      k++;
    end
    start = 1'b0;
    bus_gnt = 1'b1;

    if (abort_edge >= 0) begin
      chk({nm, "_sb_left"}, 32'(sb.size()), 32'(int'(n) - 2));
      sb.delete();
      @(posedge clock); #3;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk({nm, "_no_done"}, 32'(done_cnt - d0), 32'd0);
    end else begin
      chk({nm, "_done_edge"}, 32'(got), 32'(exp_edge));
      @(posedge clock); #1;
      @(negedge clock);
      chk({nm, "_done_width"}, {31'b0, done}, 32'd0);
      chk({nm, "_busy_after"}, {31'b0, busy}, 32'd0);
      chk({nm, "_req_after"}, {31'b0, bus_req}, 32'd0);
      repeat (8) @(negedge clock);
      chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      chk({nm, "_sb_drained"}, 32'(sb.size()), 32'd0);
      chk({nm, "_write_cycles"}, 32'(wr_cyc - w0), 32'(int'(n) + stall_len));
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0;
    len = '0; pattern = '0; bus_gnt = 1'b1; bus_data_r = '0;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_write", {31'b0, bus_write}, 32'd0);
    chk("rst_mask", {28'b0, bus_mask_w}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < 4; i++) mem[32'h10 + 32'(i)] = 32'(i + 1);
    for (int i = 0; i < 2; i++) mem[32'h30 + 32'(i)] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 8; i++) mem[32'h100 + 32'(i)] = 32'hC0DE_0000 + 32'(i);
    for (int i = 0; i < 3; i++) mem[32'h500 + 32'(i)] = 32'h5000_0000 + 32'(i * 7);

    // Plain copy
    run_cmd("copy", 1'b0, 32'h10, 32'h20, 16'd4, 32'h0, -1, 0, -1, -1);
    for (int i = 0; i < 4; i++) chk("copy_mem", rd(32'h20 + 32'(i)), 32'(i + 1));

    // Fill
    run_cmd("fill", 1'b1, 32'h0, 32'h40, 16'd3, 32'hDEADBEEF, -1, 0, -1, -1);
    for (int i = 0; i < 3; i++) chk("fill_mem", rd(32'h40 + 32'(i)), 32'hDEADBEEF);
    chk("fill_guard", rd(32'h43), 32'h43 ^ 32'h5A5A0000);

    // Zero length
    zero_mon = 1'b1;
    run_cmd("zero", 1'b0, 32'h10, 32'h80, 16'd0, 32'h0, -1, 0, -1, -1);
    zero_mon = 1'b0;
    chk("zero_quiet", {31'b0, zero_viol}, 32'd0);

    // Grant stall during the first write of a 2-word copy
    run_cmd("stall", 1'b0, 32'h30, 32'h60, 16'd2, 32'h0, 1, 3, -1, -1);
    for (int i = 0; i < 2; i++) chk("stall_mem", rd(32'h60 + 32'(i)), 32'hA000_0000 + 32'(i));

    // Reset while word 2 of 8 is being written
    run_cmd("abort", 1'b0, 32'h100, 32'h200, 16'd8, 32'h0, -1, 0, 5, -1);
    for (int i = 0; i < 2; i++) chk("abort_kept", rd(32'h200 + 32'(i)), 32'hC0DE_0000 + 32'(i));
    for (int i = 2; i < 8; i++)
      chk("abort_untouched", rd(32'h200 + 32'(i)), (32'h200 + 32'(i)) ^ 32'h5A5A0000);
    run_cmd("post_abort_fill", 1'b1, 32'h0, 32'h700, 16'd2, 32'h1234_5678, -1, 0, -1, -1);

    // Start while busy must be ignored
    run_cmd("restart", 1'b0, 32'h500, 32'h600, 16'd3, 32'h0, -1, 0, -1, 2);
    chk("restart_untouched", rd(32'h680), 32'h680 ^ 32'h5A5A0000);

    // Address wrap at the top of the space
    run_cmd("wrap", 1'b1, 32'h0, 32'hFFFF_FFFF, 16'd2, 32'h0F0F_1234, -1, 0, -1, -1);
    chk("wrap_lo", rd(32'h0), 32'h0F0F_1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
